// File: rtl/nn_pkg.sv
// Shared widths and saturation limits for the neuron activation datapath.
package nn_pkg;
  localparam int ACC_W = 36;
  localparam int OUT_W = 16;
  localparam int SH_W  = 5;

  localparam logic signed [ACC_W+1:0] OUT_MAX = 38'sd32767;
  localparam logic signed [ACC_W+1:0] OUT_MIN = -38'sd32768;
endpackage

// File: rtl/round_shift_sat.sv
// Combinational rounding right shift, plus a separate ReLU + saturate path.
// The two halves are independent so a caller can pipeline between them.
module round_shift_sat
  import nn_pkg::*;
(
  input  logic signed [ACC_W:0]   sum,
  input  logic [SH_W-1:0]         shift,
  output logic signed [ACC_W+1:0] rounded,
  input  logic signed [ACC_W+1:0] x_in,
  input  logic                    relu,
  output logic signed [OUT_W-1:0] data,
  output logic                    sat
);
  localparam logic signed [ACC_W+1:0] ONE = 38'sd1;

  logic signed [ACC_W+1:0] sum_x;
  logic signed [ACC_W+1:0] half;
  logic signed [ACC_W+1:0] clamped;

  always_comb begin
    sum_x = {sum[ACC_W], sum};
    half  = '0;
    // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
    if (shift != '0) half = ONE <<< (shift - SH_W'(1));
    rounded = (sum_x + half) >>> shift;
  end

  always_comb begin
    clamped = (relu && x_in[ACC_W+1]) ? '0 : x_in;
    data    = clamped[OUT_W-1:0];
    sat     = 1'b0;
    if (clamped > OUT_MAX) begin
      data = OUT_MAX[OUT_W-1:0];
      sat  = 1'b1;
    end else if (clamped < OUT_MIN) begin
      data = OUT_MIN[OUT_W-1:0];
      sat  = 1'b1;
    end
  end
endmodule

// File: rtl/neuron_act_requant.sv
// Three-stage bias add / rounding rescale / ReLU + saturate pipeline that turns
// a MAC accumulator into a 16-bit activation, with valid/ready on both sides.
module neuron_act_requant
  import nn_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ACC_W-1:0] in_acc,
  input  logic signed [ACC_W-1:0] in_bias,
  input  logic [SH_W-1:0]         in_shift,
  input  logic                    in_relu,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_sat,
  output logic [CNT_W-1:0]        out_count
);
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never waits for ready, and ready depends only on registered
  // stage valids and out_ready, so no combinational in_valid -> in_ready path.
  logic v1, v2, v3;
  logic adv1, adv2, adv3;

  logic signed [ACC_W:0]   s1_sum;
  logic [SH_W-1:0]         s1_shift;
  logic                    s1_relu;
  logic signed [ACC_W+1:0] s2_r;
  logic                    s2_relu;

  logic signed [ACC_W+1:0] r_next;
  logic signed [OUT_W-1:0] d_next;
  logic                    sat_next;

  assign adv3      = !v3 || out_ready;
  assign adv2      = !v2 || adv3;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v3;

  round_shift_sat u_rss (
    .sum     (s1_sum),
    .shift   (s1_shift),
    .rounded (r_next),
    .x_in    (s2_r),
    .relu    (s2_relu),
    .data    (d_next),
    .sat     (sat_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      s1_sum    <= '0;
      s1_shift  <= '0;
      s1_relu   <= 1'b0;
      s2_r      <= '0;
      s2_relu   <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_count <= '0;
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        if (in_valid) begin
          s1_sum   <= $signed({in_acc[ACC_W-1], in_acc}) + $signed({in_bias[ACC_W-1], in_bias});
          s1_shift <= in_shift;
          s1_relu  <= in_relu;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          s2_r    <= r_next;
          s2_relu <= s1_relu;
        end
      end
      // Data only moves with a valid beat, so a stalled output stays stable.
      if (adv3) begin
        v3 <= v2;
        if (v2) begin
          out_data <= d_next;
          out_sat  <= sat_next;
        end
      end
      if (v3 && out_ready) out_count <= out_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_neuron_act_requant.sv
// Bench for neuron_act_requant: vector table, directed stall/reset sequences
// and a randomized run, all checked through an expected-output queue.
module tb_neuron_act_requant;
  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [35:0] in_acc;
  logic signed [35:0] in_bias;
  logic [4:0]         in_shift;
  logic               in_relu;
  logic               out_valid;
  logic               out_ready;
  logic [15:0]        out_data;
  logic               out_sat;
  logic [15:0]        out_count;

  int total = 0;
  int bad   = 0;
  logic [16:0] exp_q[$];
  logic        rand_ready = 1'b0;

  typedef struct {
    logic signed [35:0] acc;
    logic signed [35:0] bias;
    logic [4:0]         sh;
    logic               relu;
    logic [15:0]        ed;
    logic               es;
  } vec_t;
  vec_t tbl[9];

  neuron_act_requant dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .in_bias   (in_bias),
    .in_shift  (in_shift),
    .in_relu   (in_relu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
  endtask

  function automatic logic [16:0] model(input logic signed [35:0] acc, input logic signed [35:0] bias,
                                        input logic [4:0] sh, input logic relu);
    longint s, r, one;
    one = 1;
    s = longint'(acc) + longint'(bias);
    if (sh == 0) r = s;
    else r = (s + (one << (int'(sh) - 1))) >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 32767) return {16'h7fff, 1'b1};
    if (r < -32768) return {16'h8000, 1'b1};
    return {r[15:0], 1'b0};
  endfunction

  // driver: holds in_valid until accepted, then records the expected result
  task automatic send(input logic signed [35:0] acc, input logic signed [35:0] bias,
                      input logic [4:0] sh, input logic relu, input logic [15:0] ed, input logic es);
    in_acc   = acc;
    in_bias  = bias;
    in_shift = sh;
    in_relu  = relu;
    in_valid = 1'b1;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({ed, es});
        break;
      end
      if (i > 1000) begin
        check("in_ready_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard: compare every output handshake against the queue head
  task automatic monitor();
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'({out_data, out_sat}), 64'h1ffff);
        end else begin
          e = exp_q.pop_front();
          check("out_data_sat", 64'({out_data, out_sat}), 64'(e));
        end
      end
    end
  endtask

  task automatic ready_toggler();
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int lat;
    int n;
    int seen;
    int ti;
    logic [15:0] held;
    logic signed [35:0] a, b;
    logic [4:0] s;
    logic r;
    logic [16:0] m;

    tbl[0] = '{36'sd24,       36'sd0, 5'd4, 1'b0, 16'd2,     1'b0};
    tbl[1] = '{36'sd23,       36'sd0, 5'd4, 1'b0, 16'd1,     1'b0};
    tbl[2] = '{-36'sd24,      36'sd0, 5'd4, 1'b0, 16'hffff,  1'b0};
    tbl[3] = '{-36'sd25,      36'sd0, 5'd4, 1'b0, 16'hfffe,  1'b0};
    tbl[4] = '{-36'sd500,     36'sd0, 5'd0, 1'b0, 16'hfe0c,  1'b0};
    tbl[5] = '{-36'sd500,     36'sd0, 5'd0, 1'b1, 16'h0000,  1'b0};
    tbl[6] = '{36'sd1048576,  36'sd0, 5'd4, 1'b0, 16'h7fff,  1'b1};
    tbl[7] = '{-36'sd1048576, 36'sd0, 5'd4, 1'b0, 16'h8000,  1'b1};
    tbl[8] = '{-36'sd1048576, 36'sd0, 5'd4, 1'b1, 16'h0000,  1'b0};

    in_acc = '0; in_bias = '0; in_shift = '0; in_relu = 1'b0; out_ready = 1'b0;
    fork
      monitor();
      ready_toggler();
    join_none

    // reset state
    do_reset();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);

    // single transaction with latency check
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_acc = 36'sd1000; in_bias = 36'sd24; in_shift = 5'd4; in_relu = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    check("t1_in_ready", 64'(in_ready), 64'd1);
    exp_q.push_back({16'd64, 1'b0});
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check("t1_latency", 64'(lat), 64'd3);
    check("t1_data", 64'(out_data), 64'd64);
    wait_drain();
    @(negedge clk);
    check("t1_count", 64'(out_count), 64'd1);

    // rounding, ReLU and saturation vectors
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) send(tbl[i].acc, tbl[i].bias, tbl[i].sh, tbl[i].relu, tbl[i].ed, tbl[i].es);
    wait_drain();

    // backpressure with a full pipeline
    do_reset();
    out_ready = 1'b1;
    fork
      begin
        for (int i = 1; i <= 6; i++) send(36'(i), 36'sd0, 5'd0, 1'b0, 16'(i), 1'b0);
      end
      begin
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!out_valid && n < 100);
        check("bp_first_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        held = out_data;
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", 64'(in_ready), 64'd0);
          check("bp_valid_held", 64'(out_valid), 64'd1);
          check("bp_data_stable", 64'(out_data), 64'(held));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    @(negedge clk);
    check("bp_count", 64'(out_count), 64'd6);

    // randomized valid/ready traffic
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      if ($urandom_range(0, 2) == 0) begin
        a = 36'({$urandom(), $urandom()});
        b = 36'({$urandom(), $urandom()});
        s = 5'($urandom_range(0, 31));
      end else begin
        ti = int'($urandom_range(0, 4194304)) - 2097152;
        a  = 36'(ti);
        ti = int'($urandom_range(0, 2000)) - 1000;
        b  = 36'(ti);
        s  = 5'($urandom_range(0, 8));
      end
      r = 1'($urandom_range(0, 1));
      m = model(a, b, s, r);
      send(a, b, s, r, m[16:1], m[0]);
    end
    wait_drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    @(negedge clk);
    check("rand_count", 64'(out_count), 64'd1000);

    // reset with entries in flight
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(36'(100 + i), 36'sd0, 5'd0, 1'b0, 16'(100 + i), 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst2_out_valid", 64'(out_valid), 64'd0);
    check("rst2_out_count", 64'(out_count), 64'd0);
    check("rst2_in_ready", 64'(in_ready), 64'd1);
    check("rst2_out_data", 64'({out_data, out_sat}), 64'd0);
    out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst2_no_stale", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/neuron_act_requant.md
Name: neuron_act_requant

Overview:
- Downstream of the 16x16 multiply-accumulate stage in each neuron lane; consumes the final 36-bit signed accumulator value.
- Per accepted value: adds a per-neuron bias, applies a rounding arithmetic right shift (fixed-point rescale), optional ReLU, and saturation to a 16-bit signed activation for the next layer.
- 3-stage pipeline with valid/ready on both sides. Stalls without loss and keeps ordering.

Parameters:
ACC_W, 36, signed accumulator/bias width
OUT_W, 16, signed activation width
SH_W, 5, shift-amount width (shift 0..31)
CNT_W, 16, output transaction counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  in_acc/in_bias/in_shift/in_relu valid
in_ready  out  1  block accepts input this cycle
in_acc  in  ACC_W  signed accumulator result
in_bias  in  ACC_W  signed bias, same fixed-point scale as in_acc
in_shift  in  SH_W  right-shift amount, travels with data
in_relu  in  1  1 = clamp negatives to 0
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts
out_data  out  OUT_W  signed activation
out_sat  out  1  out_data was clipped by saturation (ReLU clamp alone does not set it)
out_count  out  CNT_W  number of completed output handshakes, wraps

Behaviour:
- Reset (rst_n=0 at a clk edge): v1/v2/v3, out_data, out_sat and out_count are all cleared to 0. In-flight data is discarded. in_ready=1 in the cycle after reset.
- Handshake: input transfer on in_valid&in_ready; output transfer on out_valid&out_ready. out_valid=v3.
- Advance rules:
  - adv3 = !v3 | out_ready
  - adv2 = !v2 | adv3
  - adv1 = !v1 | adv2
  - in_ready = adv1, combinational from registered state and out_ready only. No path from in_valid to in_ready.
- A stage loads when its adv is 1. It takes the upstream valid and data. A bubble loads as valid=0.
- While out_valid=1 and out_ready=0, out_data and out_sat hold stable.
- S1 registers:
  - sum = in_acc + in_bias, sign-extended to ACC_W+1. No overflow is possible.
  - shift and relu are registered alongside.
- S2 registers:
  - shift=0: r = sum, extended to ACC_W+2.
  - otherwise: r = (sum + 2^(shift-1)) >>> shift. Arithmetic shift, ACC_W+2 bits. Ties round toward +inf.
- S3 registers:
  - If relu=1 and r<0, then x=0. Otherwise x=r.
  - If x>32767: out_data=32767, out_sat=1.
  - If x<-32768: out_data=-32768, out_sat=1.
  - Otherwise: out_data=x[OUT_W-1:0], out_sat=0.
- Latency: 3 cycles from input handshake to out_valid when out_ready stays 1. Throughput is 1/cycle.
- Capacity: 3 entries. With out_ready held low, in_ready drops once v1, v2 and v3 are all 1.
- Simultaneous output handshake and S2 valid: S3 reloads the same edge, so there is no bubble.
- out_count increments on each output handshake and wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package nn_pkg holds:
  - ACC_W, OUT_W, SH_W
  - OUT_MAX=32767 and OUT_MIN=-32768, as ACC_W+2-bit signed constants
- One sub-module, round_shift_sat: a purely combinational round-shift plus ReLU plus saturate function, reused by the pooling stage later.
- Pipeline registers and handshake logic stay in neuron_act_requant.

Test Plan:
1. acc=1000, bias=24, shift=4, relu=0, out_ready=1 -> out_data=64, out_sat=0, out_valid exactly 3 cycles after the handshake, out_count=1.
2. Rounding with shift=4, bias=0:
   - acc=24 -> 2
   - acc=23 -> 1
   - acc=-24 -> -1
   - acc=-25 -> -2
   - shift=0, acc=-500, relu=0 -> -500
   - same input with relu=1 -> 0, out_sat=0
3. Saturation with shift=4, bias=0:
   - acc=1048576 -> 32767, out_sat=1
   - acc=-1048576, relu=0 -> -32768, out_sat=1
   - acc=-1048576, relu=1 -> 0, out_sat=0
4. Backpressure:
   - Stream 6 back-to-back inputs (acc=1..6, shift=0) with out_ready=0 for 5 cycles after the first out_valid.
   - in_ready=0 while 3 entries are held.
   - out_data stays stable while stalled.
   - Outputs arrive as 1..6 in order with no duplicates; out_count=6.
5. Random valid/ready toggling, 1000 transactions -> outputs match a scoreboard model in order; out_count equals 1000 mod 2^16.
6. rst_n=0 for 1 cycle with 3 entries in flight -> next cycle out_valid=0, out_count=0, in_ready=1. No stale data appears afterwards.
